// File: rtl/lenet_frame_loader.sv
// Frame loader / sequencer for LeNet: assembles a raster pixel stream into the
// flat CNNinput bus, runs LeNet for a fixed window, then offers the class downstream.
// Optional pix_last framing check: define LENET_LOADER_FRAME_CHECK_EN.
module lenet_frame_loader #(
  parameter int DATA_WIDTH     = 16,
  parameter int ImgInW         = 32,
  parameter int ImgInH         = 32,
  parameter int RESULT_LATENCY = 75100
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                pix_valid,
  output logic                                pix_ready,
  input  logic [DATA_WIDTH-1:0]               pix_data,
  input  logic                                pix_last,
  output logic [ImgInW*ImgInH*DATA_WIDTH-1:0] CNNinput,
  output logic                                lenet_reset,
  input  logic [3:0]                          LeNetoutput,
  output logic                                result_valid,
  output logic [3:0]                          result_class,
  input  logic                                result_ready,
  output logic                                frame_error
);

  localparam int NPIX = ImgInW * ImgInH;
  localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW   = $clog2(RESULT_LATENCY + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NPIX - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(RESULT_LATENCY - 1);

`ifdef LENET_LOADER_FRAME_CHECK_EN
  localparam bit FRAME_CHECK = 1'b1;
`else
  localparam bit FRAME_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {LOAD, RUN, DONE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            lrst_q, lrst_d;
  logic            rv_q, rv_d;
  logic [3:0]      rc_q, rc_d;
  logic            ferr_q, ferr_d;
  logic            rdy_q;
  logic            wr_en, is_last, mism;
  logic [NPIX-1:0][DATA_WIDTH-1:0] cnn_q;

  assign pix_ready    = rdy_q;
  assign CNNinput     = cnn_q;
  assign lenet_reset  = lrst_q;
  assign result_valid = rv_q;
  assign result_class = rc_q;
  assign frame_error  = ferr_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    lrst_d  = lrst_q;
    rv_d    = rv_q;
    rc_d    = rc_q;
    ferr_d  = 1'b0;
    wr_en   = 1'b0;
    is_last = (idx_q == LAST_IDX);
    mism    = FRAME_CHECK && (pix_last != is_last);
    case (state_q)
      LOAD: if (pix_valid && rdy_q) begin
        wr_en = 1'b1;
        if (mism) begin
          // Discard the frame; words already written are left in place.
          ferr_d = 1'b1;
          idx_d  = '0;
        end else if (is_last) begin
          state_d = RUN;
          idx_d   = '0;
          cnt_d   = '0;
          lrst_d  = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_END) begin
          rc_d    = LeNetoutput;
          rv_d    = 1'b1;
          lrst_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (result_ready) begin
        rv_d    = 1'b0;
        state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  // Ready is registered off next state so it is low while in reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      idx_q   <= '0;
      cnt_q   <= '0;
      lrst_q  <= 1'b1;
      rv_q    <= 1'b0;
      rc_q    <= '0;
      ferr_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      lrst_q  <= lrst_d;
      rv_q    <= rv_d;
      rc_q    <= rc_d;
      ferr_q  <= ferr_d;
      rdy_q   <= (state_d == LOAD);
    end
  end

  for (genvar k = 0; k < NPIX; k++) begin : g_word
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                          cnn_q[k] <= '0;
      else if (wr_en && idx_q == IW'(k))   cnn_q[k] <= pix_data;
    end
  end

endmodule

// File: tb/tb_lenet_frame_loader.sv
// Directed bench for lenet_frame_loader: small 4x4/latency-10 instance plus a
// default-size instance for the full-latency smoke run.
module tb_lenet_frame_loader;
  localparam int DW = 16, W = 4, H = 4, L = 10;
`ifdef LENET_LOADER_FRAME_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, pix_valid, pix_ready, pix_last, lenet_reset;
  logic result_valid, result_ready, frame_error;
  logic [DW-1:0] pix_data;
  logic [W*H*DW-1:0] CNNinput;
  logic [3:0] LeNetoutput, result_class;

  logic b_valid, b_ready, b_last, b_lrst, b_rv, b_rr, b_ferr;
  logic [DW-1:0] b_data;
  logic [32*32*DW-1:0] b_cnn;
  logic [3:0] b_class;

  lenet_frame_loader #(.DATA_WIDTH(DW), .ImgInW(W), .ImgInH(H), .RESULT_LATENCY(L)) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_last(pix_last), .CNNinput(CNNinput),
    .lenet_reset(lenet_reset), .LeNetoutput(LeNetoutput), .result_valid(result_valid),
    .result_class(result_class), .result_ready(result_ready), .frame_error(frame_error));

  lenet_frame_loader big (
    .clk(clk), .reset(reset), .pix_valid(b_valid), .pix_ready(b_ready),
    .pix_data(b_data), .pix_last(b_last), .CNNinput(b_cnn),
    .lenet_reset(b_lrst), .LeNetoutput(4'd5), .result_valid(b_rv),
    .result_class(b_class), .result_ready(b_rr), .frame_error(b_ferr));

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] frame(input int base);
    logic [255:0] f;
    for (int k = 0; k < W*H; k++) f[k*DW +: DW] = 16'(base + k);
    return f;
  endfunction

  // Present one pixel and return #1 after the edge that accepts it.
  task automatic push(input logic [DW-1:0] d, input logic l);
    int t = 0;
    pix_valid = 1'b1; pix_data = d; pix_last = l;
    while (!pix_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!pix_ready) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!result_valid && cyc < 100) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic consume();
    result_ready = 1'b1; @(posedge clk); #1; result_ready = 1'b0;
  endtask

  initial begin
    int cyc, n, t;
    logic stable, seen;
    reset = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0;
    result_ready = 1'b0; LeNetoutput = 4'd7;
    b_valid = 1'b0; b_data = '0; b_last = 1'b0; b_rr = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_ready", pix_ready, 0);
    chk("rst_lrst", lenet_reset, 1);
    chk("rst_rv", result_valid, 0);
    chk("rst_rc", result_class, 0);
    chk("rst_cnn", CNNinput, 0);
    chk("rst_ferr", frame_error, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", pix_ready, 1);

    // basic frame
    for (int k = 0; k < 16; k++) push(16'(k + 1), k == 15);
    chk("basic_w0", CNNinput[15:0], 16'h0001);
    chk("basic_w15", CNNinput[255:240], 16'h0010);
    chk("basic_lrst", lenet_reset, 0);
    chk("basic_rdy", pix_ready, 0);
    wait_result(cyc);
    chk("basic_lat", cyc, 10);
    chk("basic_class", result_class, 7);
    chk("basic_lrst_back", lenet_reset, 1);

    // backpressure on result
    LeNetoutput = 4'd3; pix_valid = 1'b1; pix_data = 16'hFFFF; stable = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (result_valid !== 1'b1 || result_class !== 4'd7 || pix_ready !== 1'b0 ||
          CNNinput !== frame(1)) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    result_ready = 1'b1; @(posedge clk); #1; result_ready = 1'b0; pix_valid = 1'b0;
    chk("bp_rv", result_valid, 0);
    chk("bp_rdy", pix_ready, 1);
    chk("bp_cnn", CNNinput, frame(1));

    // bubbled input; without the frame check pix_last on pixel 9 is ignored
    LeNetoutput = 4'hA;
    for (int k = 0; k < 16; k++) begin
      push(16'(k + 32), (k == 15) || (!FC && k == 9));
      if (k == 9)  chk("bub_ferr9", frame_error, 0);
      if (k == 14) chk("bub_lrst14", lenet_reset, 1);
      if (k == 15) chk("bub_lrst15", lenet_reset, 0);
      else begin @(posedge clk); #1; end
    end
    chk("bub_cnn", CNNinput, frame(32));
    wait_result(cyc);
    chk("bub_lat", cyc, 10);
    chk("bub_class", result_class, 4'hA);
    consume();

    // reset mid-run
    for (int k = 0; k < 16; k++) push(16'(k + 64), k == 15);
    repeat (5) begin @(posedge clk); #1; end
    chk("mr_inrun", lenet_reset, 0);
    reset = 1'b0; #1;
    chk("mr_lrst", lenet_reset, 1);
    chk("mr_rv", result_valid, 0);
    chk("mr_cnn", CNNinput, 0);
    chk("mr_rdy", pix_ready, 0);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    chk("mr_rdy_rel", pix_ready, 1);
    seen = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (result_valid) seen = 1'b1; end
    chk("mr_noresult", seen, 0);

`ifdef LENET_LOADER_FRAME_CHECK_EN
    for (int k = 0; k < 10; k++) push(16'(k + 100), k == 9);
    chk("fe_pulse", frame_error, 1);
    chk("fe_lrst", lenet_reset, 1);
    chk("fe_rdy", pix_ready, 1);
    @(posedge clk); #1;
    chk("fe_once", frame_error, 0);
    for (int k = 0; k < 16; k++) push(16'(k + 200), k == 15);
    chk("fe_good_lrst", lenet_reset, 0);
    chk("fe_good_ferr", frame_error, 0);
    chk("fe_good_cnn", CNNinput, frame(200));
    wait_result(cyc);
    chk("fe_good_lat", cyc, 10);
    consume();
    for (int k = 0; k < 16; k++) push(16'(k + 300), 1'b0);
    chk("fe_nolast", frame_error, 1);
    chk("fe_nolast_lrst", lenet_reset, 1);
    chk("fe_nolast_rdy", pix_ready, 1);
`endif

    // default-size smoke
    n = 0; t = 0; b_valid = 1'b1; b_data = 16'd1;
    while (n < 1024 && t < 5000) begin
      if (b_ready) n++;
      @(posedge clk); #1; t++;
      b_data = 16'(n + 1);
      b_last = (n == 1023);
    end
    b_valid = 1'b0;
    chk("big_count", n, 1024);
    chk("big_lrst", b_lrst, 0);
    chk("big_w0", b_cnn[15:0], 16'd1);
    chk("big_w1023", b_cnn[32*32*DW-1 -: DW], 16'd1024);
    cyc = 0;
    while (!b_rv && cyc < 76000) begin @(posedge clk); #1; cyc++; end
    chk("big_lat", cyc, 75100);
    chk("big_class", b_class, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/lenet_frame_loader.md
Name: lenet_frame_loader

Overview:
- Upstream feeder and sequencer for the LeNet top.
- Accepts a raster-order pixel stream through a valid/ready handshake and assembles one ImgInW x ImgInH frame of DATA_WIDTH-bit words onto the flat CNNinput bus.
- Holds LeNet in reset while loading, releases it for a fixed inference window, then captures the 4-bit class and offers it downstream with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 16, pixel word width (IEEE half).
- ImgInW, 32, frame width in pixels.
- ImgInH, 32, frame height in pixels.
- RESULT_LATENCY, 75100, cycles LeNet runs out of reset before its output is sampled; minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- pix_valid  input  1  pixel word present.
- pix_ready  output  1  loader accepts a pixel this cycle.
- pix_data  input  DATA_WIDTH  pixel word.
- pix_last  input  1  marks final pixel of frame (used only with the optional feature).
- CNNinput  output  ImgInW*ImgInH*DATA_WIDTH  assembled frame to LeNet.
- lenet_reset  output  1  active-high reset driven to LeNet.
- LeNetoutput  input  4  class index from LeNet.
- result_valid  output  1  classification available.
- result_class  output  4  captured class.
- result_ready  input  1  downstream consumes result.
- frame_error  output  1  one-cycle pulse on framing mismatch.

Behaviour:
- Reset (reset=0, asynchronous) drives the block to these values:
  - state=LOAD, pixel index=0, latency counter=0.
  - CNNinput=0, lenet_reset=1.
  - result_valid=0, result_class=0, frame_error=0.
  - pix_ready=0 while reset is asserted.
- Reset mid-operation aborts any partial frame or running inference. No result is produced.
- pix_ready=1 exactly when state=LOAD; it is derived from the registered state only.
- Handshake: a pixel is accepted at a rising edge with pix_valid&pix_ready.
  - Pixel index k is written to CNNinput[k*DATA_WIDTH +: DATA_WIDTH], with k=row*ImgInW+col.
  - Pixel 0 sits at the LSBs.
  - k increments per accepted pixel.
- Untouched words keep their previous frame's value. CNNinput is never cleared between frames.
- LOAD -> RUN at the edge accepting pixel k=ImgInW*ImgInH-1 (edge E0). At E0:
  - lenet_reset goes 0.
  - k returns to 0.
  - the counter is cleared.
- RUN:
  - CNNinput is frozen and pix_ready=0.
  - The counter increments each cycle, width $clog2(RESULT_LATENCY+1).
  - At edge E0+RESULT_LATENCY: result_class<=LeNetoutput, result_valid<=1, lenet_reset<=1, state<=DONE.
- DONE:
  - result_valid and result_class are held stable until an edge with result_ready=1.
  - At that edge result_valid<=0 and state<=LOAD.
  - No pixel is accepted in the same cycle the result is consumed.
- result_ready is ignored outside DONE.
- pix_valid without pix_ready has no effect. pix_data is don't-care when pix_valid=0.

Optional Feature:
- Macro: LENET_LOADER_FRAME_CHECK_EN.
- Defined: pix_last is checked on every accepted pixel.
  - pix_last=1 on an index below the final index, or pix_last=0 on the final index, is a mismatch.
  - On a mismatch: frame_error pulses 1 for one cycle after the edge, k<=0, state stays LOAD, and LeNet stays in reset. The frame is discarded.
  - Written words remain in CNNinput.
- Undefined: pix_last is ignored and frame_error is tied to 0.

Test Plan (ImgInW=4, ImgInH=4, RESULT_LATENCY=10 unless stated):
- Basic frame:
  - Stimulus: after reset release, stream 16 pixels 0x0001..0x0010 back-to-back.
  - Required: CNNinput[15:0]=0x0001 and CNNinput[255:240]=0x0010.
  - Required: lenet_reset falls at the 16th accepting edge, and result_valid rises 10 edges later with result_class equal to the value driven on LeNetoutput at that edge (e.g. 4'd7).
- Backpressure on result:
  - Stimulus: hold result_ready=0 for 20 cycles, with pix_valid=1 throughout.
  - Required: result_valid and result_class stay constant, pix_ready=0 throughout, and no CNNinput change.
  - Then pulse result_ready=1: result_valid=0 next cycle and pix_ready=1.
- Bubbled input:
  - Stimulus: pix_valid toggles 1/0 each cycle.
  - Required: exactly 16 words written in order, and the transition to RUN occurs on the 16th accepted pixel only.
- Reset mid-run:
  - Stimulus: assert reset 5 cycles into RUN, then release.
  - Required: immediately lenet_reset=1, result_valid=0, CNNinput=0, pix_ready=1 one cycle after release, and no result emitted.
- Framing mismatch (with LENET_LOADER_FRAME_CHECK_EN):
  - Stimulus: pix_last=1 on pixel 9.
  - Required: frame_error pulses once, lenet_reset stays 1, and the next 16 pixels with pix_last on the 16th complete normally.
  - Stimulus: 16th pixel with pix_last=0.
  - Required: frame_error pulses and state stays LOAD.
- Default-size smoke (ImgInW=32, ImgInH=32, RESULT_LATENCY=75100):
  - Stimulus: 1024 pixels.
  - Required: result_valid asserts exactly 75100 cycles after the final accepting edge.
